// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready handshakes on both sides,
// registered reduction flags and a wrapping completed-transfer counter.
module logic_unit_pipe #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       Op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Red_and,
  output logic             Red_or,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] Count
);

  function automatic logic [WIDTH-1:0] f_logic_op(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [2:0]       op
  );
    logic [WIDTH-1:0] res;
    case (op)
      3'b000:  res = a & b;
      3'b001:  res = a | b;
      3'b010:  res = ~a;
      3'b011:  res = a;
      3'b100:  res = ~(a & b);
      3'b101:  res = ~(a | b);
      3'b110:  res = a ^ b;
      3'b111:  res = ~(a ^ b);
      default: res = {WIDTH{1'b0}};
    endcase
    return res;
  endfunction

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [2:0]       r_s1_op;
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_red_and;
  logic             r_red_or;
  logic [CNT_W-1:0] r_count;

  logic             w_out_xfer;
  logic             w_s2_load;
  logic             w_in_ready;
  logic             w_in_xfer;
  logic [WIDTH-1:0] w_s1_result;

  // S2 refills whenever it is empty or its current item leaves this cycle.
  assign w_out_xfer  = r_s2_valid & out_ready;
  assign w_s2_load   = r_s1_valid & (~r_s2_valid | out_ready);
  assign w_in_ready  = ~r_s1_valid | w_s2_load;
  assign w_in_xfer   = in_valid & w_in_ready;
  assign w_s1_result = f_logic_op(r_s1_a, r_s1_b, r_s1_op);

  // Stage 1: operand capture; data registers only move on an accepted input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= {WIDTH{1'b0}};
      r_s1_b     <= {WIDTH{1'b0}};
      r_s1_op    <= 3'b000;
    end else begin
      if (w_in_xfer) begin
        r_s1_valid <= 1'b1;
        r_s1_a     <= A;
        r_s1_b     <= B;
        r_s1_op    <= Op;
      end else if (w_s2_load) begin
        r_s1_valid <= 1'b0;
      end else begin
        r_s1_valid <= r_s1_valid;
      end
    end
  end

  // Stage 2: result and reduction flags, held stable while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_result   <= {WIDTH{1'b0}};
      r_red_and  <= 1'b0;
      r_red_or   <= 1'b0;
    end else begin
      if (w_s2_load) begin
        r_s2_valid <= 1'b1;
        r_result   <= w_s1_result;
        r_red_and  <= &w_s1_result;
        r_red_or   <= |w_s1_result;
      end else if (w_out_xfer) begin
        r_s2_valid <= 1'b0;
      end else begin
        r_s2_valid <= r_s2_valid;
      end
    end
  end

  // Completed output transfers, wrapping silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= {CNT_W{1'b0}};
    end else begin
      if (w_out_xfer) begin
        r_count <= r_count + CNT_W'(1);
      end else begin
        r_count <= r_count;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign Result    = r_result;
  assign Red_and   = r_red_and;
  assign Red_or    = r_red_or;
  assign out_valid = r_s2_valid;
  assign Count     = r_count;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard-based bench for logic_unit_pipe (WIDTH=4, CNT_W=4): a negedge monitor
// pushes expected results on input transfers and pops them on output transfers.
module tb_logic_unit_pipe;

  logic       clk;
  logic       rst_n;
  logic [3:0] A;
  logic [3:0] B;
  logic [2:0] Op;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] Result;
  logic       Red_and;
  logic       Red_or;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] Count;

  int         n_cmp;
  int         n_err;
  logic [5:0] sb[$];
  logic [3:0] exp_cnt;
  logic       prev_stall;
  logic [6:0] prev_out;

  logic_unit_pipe #(.WIDTH(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .Op(Op),
    .in_valid(in_valid), .in_ready(in_ready),
    .Result(Result), .Red_and(Red_and), .Red_or(Red_or),
    .out_valid(out_valid), .out_ready(out_ready), .Count(Count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {result, &result, |result}
  function automatic logic [5:0] model(input logic [3:0] a, input logic [3:0] b,
                                       input logic [2:0] op);
    logic [3:0] r;
    logic [3:0] t;
    if (op[1:0] == 2'b00)      t = a & b;
    else if (op[1:0] == 2'b01) t = a | b;
    else if (op[1:0] == 2'b10) t = (op[2]) ? (a ^ b) : a;
    else                       t = (op[2]) ? (a ^ b) : a;
    // ops 010/111 are inverted forms of 011/110; ops 100/101 invert 000/001
    case (op)
      3'b010, 3'b100, 3'b101, 3'b111: r = ~t;
      default:                        r = t;
    endcase
    return {r, (r == 4'b1111), (r != 4'b0000)};
  endfunction

  // Scoreboard monitor, sampling away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      exp_cnt    = 4'd0;
      prev_stall = 1'b0;
    end else begin
      n_cmp++;
      if (Count !== exp_cnt) begin
        n_err++;
        $display("FAIL count_track: got %0d expected %0d", Count, exp_cnt);
      end
      if (prev_stall) begin
        n_cmp++;
        if ({out_valid, Result, Red_and, Red_or} !== prev_out) begin
          n_err++;
          $display("FAIL stall_stable: got %b expected %b",
                   {out_valid, Result, Red_and, Red_or}, prev_out);
        end
      end
      if (out_valid && sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_item: got out_valid=1 Result=%b expected empty pipe", Result);
      end else if (out_valid && out_ready) begin
        logic [5:0] e;
        e = sb.pop_front();
        n_cmp++;
        if ({Result, Red_and, Red_or} !== e) begin
          n_err++;
          $display("FAIL sb_data: got %b/%b/%b expected %b/%b/%b",
                   Result, Red_and, Red_or, e[5:2], e[1], e[0]);
        end
        exp_cnt = exp_cnt + 4'd1;
      end
      if (in_valid && in_ready) sb.push_back(model(A, B, Op));
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_valid, Result, Red_and, Red_or};
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while ((sb.size() != 0 || out_valid) && k < 50) begin
      cyc();
      k++;
    end
    cyc();
    n_cmp++;
    if (sb.size() != 0 || out_valid) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    A = 4'd0; B = 4'd0; Op = 3'd0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({out_valid, in_ready, Result, Red_and, Red_or, Count} !== {1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0}) begin
      n_err++;
      $display("FAIL reset_state: got ov=%b ir=%b R=%b ra=%b ro=%b C=%0d expected 0,1,0000,0,0,0",
               out_valid, in_ready, Result, Red_and, Red_or, Count);
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_single();
    A = 4'b1100; B = 4'b1010; Op = 3'b000; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL single_accept: got in_ready=%b expected 1", in_ready);
    end
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL single_early: got out_valid=%b expected 0", out_valid);
    end
    @(negedge clk);
    n_cmp++;
    if ({out_valid, Result, Red_and, Red_or} !== {1'b1, 4'b1000, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL single_result: got ov=%b R=%b ra=%b ro=%b expected 1 1000 0 1",
               out_valid, Result, Red_and, Red_or);
    end
    @(negedge clk);
    n_cmp++;
    if (Count !== 4'd1) begin
      n_err++; $display("FAIL single_count: got %0d expected 1", Count);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] tbl [8];
    tbl = '{4'b1000, 4'b1110, 4'b0011, 4'b1100, 4'b0111, 4'b0001, 4'b0110, 4'b1001};
    drain();
    A = 4'b1100; B = 4'b1010; out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_valid = (k < 8);
      Op = 3'(k);
      @(negedge clk);
      if (k >= 2) begin
        n_cmp++;
        if ({out_valid, Result} !== {1'b1, tbl[k-2]}) begin
          n_err++;
          $display("FAIL b2b_op%0d: got ov=%b R=%b expected 1 %b", k - 2, out_valid, Result, tbl[k-2]);
        end
      end
      cyc();
    end
    drain();
  endtask

  task automatic test_extremes();
    out_ready = 1'b1;
    A = 4'b1111; B = 4'b1111; Op = 3'b111; in_valid = 1'b1;
    cyc();
    A = 4'b0000; B = 4'b0101; Op = 3'b011;
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, Result, Red_and, Red_or} !== {1'b1, 4'b1111, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL xnor_ones: got ov=%b R=%b ra=%b ro=%b expected 1 1111 1 1",
               out_valid, Result, Red_and, Red_or);
    end
    cyc();
    @(negedge clk);
    n_cmp++;
    if ({out_valid, Result, Red_and, Red_or} !== {1'b1, 4'b0000, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL buf_zero: got ov=%b R=%b ra=%b ro=%b expected 1 0000 0 0",
               out_valid, Result, Red_and, Red_or);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int acc;
    acc = 0;
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      A = 4'($urandom); B = 4'($urandom); Op = 3'($urandom);
      @(negedge clk);
      if (in_ready) acc++;
      cyc();
    end
    @(negedge clk);
    n_cmp++;
    if (acc != 2 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bp_accept: got %0d accepted in_ready=%b expected 2 and 0", acc, in_ready);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1;
    A = 4'b0110; B = 4'b0011; Op = 3'b001;
    cyc(); cyc();
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, Result, Count, in_ready} !== {1'b0, 4'd0, 4'd0, 1'b1}) begin
      n_err++;
      $display("FAIL mid_reset: got ov=%b R=%b C=%0d ir=%b expected 0 0000 0 1",
               out_valid, Result, Count, in_ready);
    end
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL post_reset_c%0d: got ov=%b ir=%b expected 0 1", k, out_valid, in_ready);
      end
    end
    cyc();
  endtask

  task automatic test_random();
    for (int k = 0; k < 200; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      A = 4'($urandom); B = 4'($urandom); Op = 3'($urandom);
      cyc();
    end
    drain();
  endtask

  task automatic test_count_wrap();
    test_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      A = 4'($urandom); B = 4'($urandom); Op = 3'($urandom);
      cyc();
    end
    drain();
    n_cmp++;
    if (Count !== 4'd0) begin
      n_err++; $display("FAIL wrap16: got %0d expected 0", Count);
    end
    in_valid = 1'b1; A = 4'b1001; Op = 3'b010;
    cyc();
    drain();
    n_cmp++;
    if (Count !== 4'd1) begin
      n_err++; $display("FAIL wrap17: got %0d expected 1", Count);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_extremes();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_count_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
